// File: rtl/bus_pkg.sv
// Shared bus definitions: default widths, DMA state encoding
// and the values driven on an idle bus.
package bus_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } dma_state_e;

  localparam logic IDLE_REQ = 1'b0;
  localparam logic IDLE_WR  = 1'b0;

endpackage

// File: rtl/bus_dma_master_if.sv
// Master-side port of the shared bus: request, address,
// data and the arbiter grant.
interface bus_dma_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();

  logic              M_req;
  logic              M_wr;
  logic [ADDR_W-1:0] M_address;
  logic [DATA_W-1:0] M_dout;
  logic              M_grant;
  logic [DATA_W-1:0] M_din;

  modport master (
    output M_req, M_wr, M_address, M_dout,
    input  M_grant, M_din
  );

  modport slave (
    input  M_req, M_wr, M_address, M_dout,
    output M_grant, M_din
  );

endinterface

// File: rtl/bus_dma_master.sv
// Word-by-word memory-to-memory copy engine acting as a
// bus master; read, then write, per word, until length is spent.
module bus_dma_master
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [7:0]        length,
  output logic              busy,
  output logic              done,
  bus_dma_master_if.master  m
);

  dma_state_e        state;
  logic [ADDR_W-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
  logic [7:0]        remaining;
  logic              req_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;

  assign m.M_req     = req_q;
  assign m.M_wr      = wr_q;
  assign m.M_address = addr_q;
  assign m.M_dout    = dout_q;

  // Bus outputs are set for the state being entered,
  // so they stay stable while a grant is withheld.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_q     <= IDLE_REQ;
      wr_q      <= IDLE_WR;
      addr_q    <= '0;
      dout_q    <= '0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (length != 8'd0) begin
              cur_src   <= src_addr;
              cur_dst   <= dst_addr;
              remaining <= length;
              req_q     <= 1'b1;
              wr_q      <= 1'b0;
              addr_q    <= src_addr;
              state     <= RD_ADDR;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RD_ADDR: begin
          if (m.M_grant) state <= RD_DATA;
        end
        RD_DATA: begin
          // The write-data register doubles as the word buffer.
          dout_q <= m.M_din;
          wr_q   <= 1'b1;
          addr_q <= cur_dst;
          state  <= WR;
        end
        WR: begin
          if (m.M_grant) begin
            cur_src   <= cur_src + ADDR_W'(1);
            cur_dst   <= cur_dst + ADDR_W'(1);
            remaining <= remaining - 8'd1;
            dout_q    <= '0;
            wr_q      <= 1'b0;
            if (remaining == 8'd1) begin
              req_q  <= IDLE_REQ;
              addr_q <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              addr_q <= cur_src + ADDR_W'(1);
              state  <= RD_ADDR;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed and randomized copies against a memory-level
// reference model, with grant stalls and mid-copy reset.
module tb_bus_dma_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] length;
  logic       busy;
  logic       done;

  bus_dma_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  bus_dma_master #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .m        (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem  [256];
  logic [31:0] expm [256];
  logic [7:0]  wlog [$];

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;
  bit rnd    = 1'b0;

  // Slave memory: read data returns one cycle after the address.
  always @(posedge clk) begin
    if (bus.M_req && bus.M_grant) begin
      if (bus.M_wr) begin
        mem[bus.M_address] <= bus.M_dout;
        wlog.push_back(bus.M_address);
      end else begin
        bus.M_din <= mem[bus.M_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rnd) bus.M_grant = ($urandom_range(3) != 0);
  endtask

  task automatic launch(input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] l);
    src_addr = s;
    dst_addr = d;
    length   = l;
    start    = 1'b1;
    cyc      = 0;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    while (!done && cyc < budget) step();
    at = done ? cyc : -1;
  endtask

  initial begin
    int at;
    bit ok;
    bit seen;
    logic [31:0] v [4];
    logic [31:0] keep;
    int mism;
    logic [7:0] s, d, l, ia, ib;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset    = 1'b1;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    bus.M_grant = 1'b1;
    step();
    step();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_req",  64'(bus.M_req), 64'(0));
    chk("rst_wr",   64'(bus.M_wr), 64'(0));
    chk("rst_addr", 64'(bus.M_address), 64'(0));
    chk("rst_dout", 64'(bus.M_dout), 64'(0));
    reset = 1'b0;
    step();

    // single word
    mem[8'h10] = 32'hDEADBEEF;
    launch(8'h10, 8'h20, 8'd1);
    chk("single_req", 64'(bus.M_req), 64'(1));
    wait_done(50, at);
    chk("single_done_cyc", 64'(at), 64'(4));
    step();
    chk("single_busy_after", 64'(busy), 64'(0));
    chk("single_data", 64'(mem[8'h20]), 64'(32'hDEADBEEF));

    // burst of four
    for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
    launch(8'h00, 8'h40, 8'd4);
    wait_done(60, at);
    chk("burst_done_cyc", 64'(at), 64'(13));
    step();
    for (int i = 0; i < 4; i++)
      chk($sformatf("burst_data%0d", i), 64'(mem[8'h40 + i]), 64'(i + 1));

    // grant withheld five cycles in RD_ADDR and in WR
    mem[8'h30] = 32'hCAFE0123;
    bus.M_grant = 1'b0;
    launch(8'h30, 8'h50, 8'd1);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(bus.M_req === 1'b1 && bus.M_wr === 1'b0 &&
            bus.M_address === 8'h30)) ok = 1'b0;
      step();
    end
    chk("stall_rd_stable", 64'(ok), 64'(1));
    bus.M_grant = 1'b1;
    step();
    bus.M_grant = 1'b0;
    step();
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(bus.M_req === 1'b1 && bus.M_wr === 1'b1 &&
            bus.M_address === 8'h50 &&
            bus.M_dout === 32'hCAFE0123)) ok = 1'b0;
      step();
    end
    chk("stall_wr_stable", 64'(ok), 64'(1));
    bus.M_grant = 1'b1;
    wait_done(60, at);
    chk("stall_done_cyc", 64'(at), 64'(14));
    step();
    chk("stall_data", 64'(mem[8'h50]), 64'(32'hCAFE0123));

    // address wrap; second read sees the first write
    mem[8'hFE] = 32'hA1A1A1A1;
    mem[8'hFF] = 32'hB2B2B2B2;
    mem[8'h00] = 32'h0;
    wlog.delete();
    launch(8'hFE, 8'hFF, 8'd2);
    wait_done(60, at);
    chk("wrap_done_cyc", 64'(at), 64'(7));
    step();
    chk("wrap_nwrites", 64'(wlog.size()), 64'(2));
    if (wlog.size() == 2) begin
      chk("wrap_waddr0", 64'(wlog[0]), 64'(8'hFF));
      chk("wrap_waddr1", 64'(wlog[1]), 64'(8'h00));
    end
    chk("wrap_mem_ff", 64'(mem[8'hFF]), 64'(32'hA1A1A1A1));
    chk("wrap_mem_00", 64'(mem[8'h00]), 64'(32'hA1A1A1A1));

    // zero length
    launch(8'h11, 8'h22, 8'd0);
    chk("len0_done", 64'(done), 64'(1));
    chk("len0_req", 64'(bus.M_req), 64'(0));
    chk("len0_busy", 64'(busy), 64'(1));
    step();
    chk("len0_busy_after", 64'(busy), 64'(0));
    chk("len0_done_after", 64'(done), 64'(0));

    // start while busy is ignored
    for (int i = 0; i < 3; i++) v[i] = mem[8'h60 + i];
    keep = mem[8'h90];
    wlog.delete();
    launch(8'h60, 8'h70, 8'd3);
    step();
    step();
    src_addr = 8'h80;
    dst_addr = 8'h90;
    length   = 8'd5;
    start    = 1'b1;
    step();
    start    = 1'b0;
    wait_done(80, at);
    chk("busy_start_done_cyc", 64'(at), 64'(10));
    step();
    chk("busy_start_nwrites", 64'(wlog.size()), 64'(3));
    for (int i = 0; i < 3; i++)
      chk($sformatf("busy_start_data%0d", i), 64'(mem[8'h70 + i]), 64'(v[i]));
    chk("busy_start_untouched", 64'(mem[8'h90]), 64'(keep));

    // reset during the write of word 2 of 4
    for (int i = 0; i < 4; i++) begin
      v[i] = mem[8'hA0 + i];
      mem[8'hB0 + i] = 32'h0;
    end
    launch(8'hA0, 8'hB0, 8'd4);
    for (int i = 0; i < 5; i++) step();
    chk("rstmid_in_wr2", 64'({bus.M_wr, bus.M_address}), 64'({1'b1, 8'hB1}));
    bus.M_grant = 1'b0;
    reset = 1'b1;
    step();
    chk("rstmid_outs",
        64'({busy, done, bus.M_req, bus.M_wr, bus.M_address, bus.M_dout}),
        64'(0));
    reset = 1'b0;
    bus.M_grant = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done || bus.M_req) seen = 1'b1;
      step();
    end
    chk("rstmid_no_done", 64'(seen), 64'(0));
    chk("rstmid_word1", 64'(mem[8'hB0]), 64'(v[0]));
    chk("rstmid_word2", 64'(mem[8'hB1]), 64'(0));

    // randomized copies under random grant
    rnd = 1'b1;
    for (int t = 0; t < 8; t++) begin
      s = 8'($urandom);
      d = 8'($urandom);
      l = 8'($urandom_range(1, 8));
      for (int i = 0; i < 256; i++) expm[i] = mem[i];
      for (int i = 0; i < int'(l); i++) begin
        ia = s + 8'(i);
        ib = d + 8'(i);
        expm[ib] = expm[ia];
      end
      launch(s, d, l);
      wait_done(1 + 3 * int'(l) + 300, at);
      chk($sformatf("rand%0d_done_seen", t), 64'(at != -1), 64'(1));
      chk($sformatf("rand%0d_not_early", t),
          64'(at >= 1 + 3 * int'(l)), 64'(1));
      step();
      mism = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== expm[i]) mism++;
      chk($sformatf("rand%0d_mem", t), 64'(mism), 64'(0));
      chk($sformatf("rand%0d_idle", t), 64'(busy), 64'(0));
    end
    rnd = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
